win_line_buf: RTL and testbench

Parametrised sliding-window line buffer. Takes a raster pixel stream with hsync/vsync and stores the most recent WIN lines in rotating line memories. For every pixel of the current line it emits a WIN x WIN pixel window through a valid/ready output FIFO. It feeds the colour-classification and filter stages downstream of camera capture.

---
 rtl/win_line_buf.sv | 224 ++++++++++++++++++++++
 tb/tb_win_line_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/win_line_buf.sv
// Sliding-window line buffer: keeps the last WIN raster lines and emits a
// WIN x WIN pixel window per pixel through a valid/ready output FIFO.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            block enable (input pixels ignored and state held when low;
//                 the output FIFO keeps draining)
//   pdata, pvld   input pixel stream
//   hsync, vsync  line / frame sync; a falling edge ends the line / frame
//   out_data      window; element [r][c] at ((r*WIN+c)*PIX_W)+:PIX_W,
//                 row 0 = oldest line, col 0 = oldest pixel
//   out_vld       out_data valid
//   out_rdy       downstream ready
//   ovf           sticky overflow / dropped-data flag
//
// Build option: define WIN_PAD_EN to also emit zero-padded windows for the
// first WIN-1 columns of each line (LINE_W windows per line).

module win_line_buf #(
  parameter int PIX_W      = 24,
  parameter int LINE_W     = 640,
  parameter int WIN        = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PIX_W-1:0]         pdata,
  input  logic                     pvld,
  input  logic                     hsync,
  input  logic                     vsync,
  output logic [WIN*WIN*PIX_W-1:0] out_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     ovf
);

  localparam int AW  = $clog2(LINE_W + 1);
  localparam int LAW = $clog2(LINE_W);
  localparam int SW  = $clog2(WIN);
  localparam int CW  = $clog2(WIN);
  localparam int FW  = $clog2(FIFO_DEPTH);
  localparam int WW  = WIN * WIN * PIX_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0]       hs_q;
  logic [1:0]       vs_q;
  logic [1:0]       state_q;
  logic [WIN-1:0]   sel_q;
  logic [AW-1:0]    waddr_q;
  logic [CW-1:0]    col_cnt_q;
  logic [CW-1:0]    line_cnt_q;
  logic             ovf_q;
  logic             ovf_d;

  logic [PIX_W-1:0] mem_q [WIN][LINE_W];
  logic [PIX_W-1:0] rd_q  [WIN-1];
  logic [PIX_W-1:0] pd_q;
  logic             v1_q;
  logic             v2_q;
  logic [WW-1:0]    win_q;
  logic [WW-1:0]    win_d;

  logic [WW-1:0]    fifo_q [FIFO_DEPTH];
  logic [FW:0]      wptr_q;
  logic [FW:0]      rptr_q;

  logic             ln_sync;
  logic             fm_sync;
  logic             acc;
  logic             wr_ok;
  logic             wr_drop;
  logic             sync_drop;
  logic             stream;
  logic             emit_ok;
  logic [LAW-1:0]   ra;
  logic [SW-1:0]    sel_idx;
  logic [SW-1:0]    ridx [WIN-1];

  logic             empty;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push;
  logic             fifo_drop;

  assign ln_sync   = hs_q[1] & ~hs_q[0];
  assign fm_sync   = vs_q[1] & ~vs_q[0];
  assign acc       = pvld & en & ~ln_sync & ~fm_sync;
  assign sync_drop = pvld & en & (ln_sync | fm_sync);
  // waddr saturates at LINE_W; anything beyond the line memory is dropped
  assign wr_ok     = acc & (waddr_q < AW'(LINE_W));
  assign wr_drop   = acc & ~wr_ok;
  assign stream    = (state_q == STREAM);
  assign ra        = waddr_q[LAW-1:0];

`ifdef WIN_PAD_EN
  assign emit_ok = 1'b1;
`else
  // col_cnt counts columns already in the window before this shift
  assign emit_ok = (col_cnt_q == CW'(WIN - 1));
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIN; i++) begin
      if (sel_q[i]) sel_idx = SW'(i);
    end
  end

  // Oldest line sits just after the current one in rotation order
  always_comb begin
    int s;
    for (int r = 0; r < WIN - 1; r++) begin
      s = int'(sel_idx) + 1 + r;
      if (s >= WIN) s = s - WIN;
      ridx[r] = SW'(s);
    end
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_d[(r*WIN+c)*PIX_W +: PIX_W] =
          win_q[(r*WIN+c+1)*PIX_W +: PIX_W];
      end
    end
    for (int r = 0; r < WIN - 1; r++) begin
      win_d[(r*WIN+WIN-1)*PIX_W +: PIX_W] = rd_q[r];
    end
    win_d[((WIN-1)*WIN+WIN-1)*PIX_W +: PIX_W] = pd_q;
  end

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[FW] != rptr_q[FW]) &&
                     (wptr_q[FW-1:0] == rptr_q[FW-1:0]);
  assign out_vld   = ~empty;
  assign out_data  = out_vld ? fifo_q[rptr_q[FW-1:0]] : '0;
  assign pop       = out_vld & out_rdy;
  assign push_req  = v2_q & en;
  // a simultaneous pop frees the slot, so a full FIFO can still accept
  assign push      = push_req & (~full | pop);
  assign fifo_drop = push_req & full & ~pop;

  assign ovf_d = ovf_q | sync_drop | wr_drop | fifo_drop;
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[sel_idx][ra] <= pdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[FW-1:0]] <= win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= '0;
      vs_q       <= '0;
      state_q    <= IDLE;
      sel_q      <= WIN'(1);
      waddr_q    <= '0;
      col_cnt_q  <= '0;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
      pd_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      win_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int r = 0; r < WIN - 1; r++) rd_q[r] <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (en) begin
        hs_q <= {hs_q[0], hsync};
        vs_q <= {vs_q[0], vsync};
        v1_q <= wr_ok & stream;
        v2_q <= v1_q & emit_ok;
        if (wr_ok & stream) begin
          pd_q <= pdata;
          for (int r = 0; r < WIN - 1; r++) begin
            rd_q[r] <= mem_q[ridx[r]][ra];
          end
        end
        if (fm_sync) begin
          waddr_q    <= '0;
          col_cnt_q  <= '0;
          line_cnt_q <= '0;
          sel_q      <= WIN'(1);
          state_q    <= IDLE;
          win_q      <= '0;
        end else if (ln_sync) begin
          waddr_q   <= '0;
          col_cnt_q <= '0;
          win_q     <= '0;
          sel_q     <= {sel_q[WIN-2:0], sel_q[WIN-1]};
          if (line_cnt_q != CW'(WIN - 1)) begin
            line_cnt_q <= line_cnt_q + 1'b1;
          end
          if (state_q == FILL && line_cnt_q == CW'(WIN - 2)) begin
            state_q <= STREAM;
          end
        end else begin
          if (wr_ok) waddr_q <= waddr_q + 1'b1;
          if (acc && state_q == IDLE) state_q <= FILL;
          if (v1_q) begin
            win_q <= win_d;
            if (col_cnt_q != CW'(WIN - 1)) begin
              col_cnt_q <= col_cnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_win_line_buf.sv
// Directed bench for win_line_buf (LINE_W=8, WIN=3): fill/stream, backpressure
// on a FIFO_DEPTH=4 copy, long line, mid-frame vsync and reset.

module tb_win_line_buf;

`ifdef WIN_PAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif
  localparam int NW = 6 + PAD;
  localparam int WW = 216;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic [23:0]   pdata = '0;
  logic          pvld = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          rdy = 1'b1;
  logic          rdy4 = 1'b0;
  logic [WW-1:0] odata;
  logic [WW-1:0] odata4;
  logic          ovld;
  logic          ovld4;
  logic          ovf;
  logic          ovf4;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc [16];
  logic [WW-1:0] q0 [$];
  int            c0 [$];
  logic [WW-1:0] q4 [$];

  win_line_buf #(
    .PIX_W(24), .LINE_W(8), .WIN(3), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pdata(pdata), .pvld(pvld),
    .hsync(hsync), .vsync(vsync), .out_data(odata), .out_vld(ovld),
    .out_rdy(rdy), .ovf(ovf)
  );

  win_line_buf #(
    .PIX_W(24), .LINE_W(8), .WIN(3), .FIFO_DEPTH(4)
  ) dut4 (
    .clk(clk), .rst(rst), .en(en), .pdata(pdata), .pvld(pvld),
    .hsync(hsync), .vsync(vsync), .out_data(odata4), .out_vld(ovld4),
    .out_rdy(rdy4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovld && rdy) begin
      q0.push_back(odata);
      c0.push_back(cyc);
    end
    if (ovld4 && rdy4) q4.push_back(odata4);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] pix(int l, int c);
    return {8'h0, 8'(l), 8'(c)};
  endfunction

  function automatic logic [WW-1:0] exp_win(int base, int k);
    logic [WW-1:0] w;
    int col;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        col = k + c - PAD;
        if (col >= 0) w[(r*3+c)*24 +: 24] = pix(base + r, col);
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int lval, input int n);
    for (int c = 0; c < n; c++) begin
      step();
      pdata = pix(lval, c);
      pvld = 1'b1;
      acc_cyc[c] = cyc;
    end
    step();
    pvld = 1'b0;
    repeat (3) step();
    hsync = 1'b0;
    repeat (3) step();
    hsync = 1'b1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    q0.delete();
    c0.delete();
    q4.delete();
  endtask

  task automatic chk_wins(input string tag, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_win%0d", tag, k),
          (k < q0.size()) ? q0[k] : '1, exp_win(base, k));
    end
  endtask

  initial begin
    int lat;

    // reset with random inputs
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pdata = 24'($urandom);
      pvld  = 1'($urandom);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      en    = 1'($urandom);
      rdy   = 1'($urandom);
      step();
    end
    rst = 1'b0;
    pdata = '0;
    pvld = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    en = 1'b1;
    rdy = 1'b1;
    rdy4 = 1'b0;
    chk("rst_vld", ovld, 0);
    chk("rst_data", odata, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_vld4", ovld4, 0);
    chk("rst_data4", odata4, 0);
    chk("rst_ovf4", ovf4, 0);
    q0.delete();
    c0.delete();
    q4.delete();

    // fill / stream, with the depth-4 copy backpressured
    send_line(0, 8);
    send_line(1, 8);
    chk("fill_nowin", q0.size(), 0);
    send_line(2, 8);
    repeat (10) step();
    chk("strm_cnt", q0.size(), NW);
    lat = (c0.size() > 0) ? (c0[0] - acc_cyc[2-PAD]) : -1;
    chk("strm_lat", lat, 3);
    chk_wins("strm", 0, NW);
    chk("strm_ovf", ovf, 0);
    chk("bp_ovf", ovf4, 1);
    chk("bp_vld", ovld4, 1);
    chk("bp_none", q4.size(), 0);
    rdy4 = 1'b1;
    repeat (10) step();
    chk("bp_cnt", q4.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_win%0d", k),
          (k < q4.size()) ? q4[k] : '1, exp_win(0, k));
    end

    // long line
    do_reset();
    chk("long_ovf0", ovf, 0);
    send_line(0, 10);
    chk("long_ovf1", ovf, 1);
    send_line(1, 8);
    send_line(2, 8);
    repeat (10) step();
    chk("long_cnt", q0.size(), NW);
    chk_wins("long", 0, NW);

    // mid-frame vsync
    do_reset();
    rdy4 = 1'b0;
    for (int l = 0; l < 4; l++) send_line(l, 8);
    vsync = 1'b0;
    repeat (3) step();
    vsync = 1'b1;
    repeat (3) step();
    chk("fa_cnt", q0.size(), 2 * NW);
    q0.delete();
    c0.delete();
    send_line(4, 8);
    send_line(5, 8);
    repeat (10) step();
    chk("fb_nowin", q0.size(), 0);
    send_line(6, 8);
    repeat (10) step();
    chk("fb_cnt", q0.size(), NW);
    chk_wins("fb", 4, NW);

    // reset while the FIFO holds data
    chk("mid_vld_pre", ovld4, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_vld_post", ovld4, 0);
    chk("mid_ovf_post", ovf4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
